bf_loader: RTL and testbench



---
 rtl/bf_loader.sv | 194 +++++++++++++++++++
 tb/tb_bf_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_loader.sv
// Brainfuck program loader: encodes an ASCII command stream into 3-bit instructions,
// writes them to program memory, pads with NOP and releases the core when the image is valid.
module bf_loader #(
    parameter int PRGMEM_ADDR_WIDTH = 8,
    parameter int STACK_ADDR_WIDTH  = 4
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_load,
    input  logic                         i_byte_valid,
    input  logic [7:0]                   i_byte_data,
    input  logic                         i_byte_last,
    output logic                         o_byte_ready,
    output logic                         o_prgmem_in,
    output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
    output logic [2:0]                   o_prgmem_data,
    output logic                         o_core_reset_n,
    output logic                         o_busy,
    output logic                         o_error,
    output logic [1:0]                   o_error_code,
    output logic [PRGMEM_ADDR_WIDTH-1:0] o_length
);

    localparam int AW = PRGMEM_ADDR_WIDTH;
    localparam int SW = STACK_ADDR_WIDTH;

    localparam logic [AW-1:0] PTR_MAX   = '1;
    localparam logic [SW:0]   DEPTH_MAX = (SW+1)'(1) << SW;

    localparam logic [1:0] ERR_BALANCE = 2'b01;
    localparam logic [1:0] ERR_DEPTH   = 2'b10;
    localparam logic [1:0] ERR_LENGTH  = 2'b11;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_OPEN  = 3'b110;
    localparam logic [2:0] OP_CLOSE = 3'b111;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FILL,
        ST_RUN,
        ST_ERROR
    } state_t;

    function automatic logic [2:0] encode(input logic [7:0] b);
        case (b)
            8'h2B:   encode = 3'b010;  // +
            8'h2D:   encode = 3'b011;  // -
            8'h3E:   encode = 3'b100;  // >
            8'h3C:   encode = 3'b101;  // <
            8'h5B:   encode = 3'b110;  // [
            8'h5D:   encode = 3'b111;  // ]
            default: encode = OP_NOP;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [SW:0]     depth_q, depth_d;
    logic [AW-1:0]   length_q, length_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [2:0]      wr_data_q, wr_data_d;
    logic            core_rst_n_q, core_rst_n_d;
    logic            busy_q, busy_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            accept;
    logic [2:0]      op;
    logic [SW:0]     depth_step;

    assign accept = i_byte_valid && (state_q == ST_LOAD);
    assign op     = encode(i_byte_data);

    always_comb begin
        depth_step = depth_q;
        if (op == OP_OPEN) begin
            depth_step = depth_q + 1'b1;
        end else if (op == OP_CLOSE) begin
            depth_step = depth_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        depth_d    = depth_q;
        length_d   = length_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_code_d = err_code_q;

        if (i_load) begin
            // A byte handed over alongside i_load is deliberately dropped.
            state_d    = ST_LOAD;
            ptr_d      = '0;
            depth_d    = '0;
            length_d   = '0;
            err_code_d = 2'b00;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        if (op == OP_CLOSE && depth_q == '0) begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_BALANCE;
                        end else if (op == OP_OPEN && depth_q == DEPTH_MAX) begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_DEPTH;
                        end else if (op != OP_NOP && ptr_q == PTR_MAX) begin
                            // The top address must stay NOP so the PC never wraps into code.
                            state_d    = ST_ERROR;
                            err_code_d = ERR_LENGTH;
                        end else begin
                            if (op != OP_NOP) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = op;
                                ptr_d     = ptr_q + 1'b1;
                                length_d  = length_q + 1'b1;
                                depth_d   = depth_step;
                            end
                            if (i_byte_last) begin
                                if (depth_step != '0) begin
                                    state_d    = ST_ERROR;
                                    err_code_d = ERR_BALANCE;
                                end else begin
                                    state_d = ST_FILL;
                                end
                            end
                        end
                    end
                end
                ST_FILL: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = OP_NOP;
                    if (ptr_q == PTR_MAX) begin
                        state_d = ST_RUN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Status flags track the state being entered so they line up with it.
        core_rst_n_d = (state_d == ST_RUN);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_FILL);
        error_d      = (state_d == ST_ERROR);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            depth_q      <= '0;
            length_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            depth_q      <= depth_d;
            length_q     <= length_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign o_byte_ready   = (state_q == ST_LOAD);
    assign o_prgmem_in    = wr_en_q;
    assign o_prgmem_addr  = wr_addr_q;
    assign o_prgmem_data  = wr_data_q;
    assign o_core_reset_n = core_rst_n_q;
    assign o_busy         = busy_q;
    assign o_error        = error_q;
    assign o_error_code   = err_code_q;
    assign o_length       = length_q;

endmodule

// File: tb/tb_bf_loader.sv
// Bench for bf_loader: expected memory writes are queued by the stimulus and
// checked by an independent write monitor; status outputs are checked directly.
module tb_bf_loader;

    localparam int AW    = 8;
    localparam int SW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_load;
    logic          i_byte_valid;
    logic [7:0]    i_byte_data;
    logic          i_byte_last;
    logic          o_byte_ready;
    logic          o_prgmem_in;
    logic [AW-1:0] o_prgmem_addr;
    logic [2:0]    o_prgmem_data;
    logic          o_core_reset_n;
    logic          o_busy;
    logic          o_error;
    logic [1:0]    o_error_code;
    logic [AW-1:0] o_length;

    int nvec  = 0;
    int nfail = 0;
    int expq[$];

    always #5 clk = ~clk;

    bf_loader #(.PRGMEM_ADDR_WIDTH(AW), .STACK_ADDR_WIDTH(SW)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_load         (i_load),
        .i_byte_valid   (i_byte_valid),
        .i_byte_data    (i_byte_data),
        .i_byte_last    (i_byte_last),
        .o_byte_ready   (o_byte_ready),
        .o_prgmem_in    (o_prgmem_in),
        .o_prgmem_addr  (o_prgmem_addr),
        .o_prgmem_data  (o_prgmem_data),
        .o_core_reset_n (o_core_reset_n),
        .o_busy         (o_busy),
        .o_error        (o_error),
        .o_error_code   (o_error_code),
        .o_length       (o_length)
    );

    // Write monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (o_prgmem_in === 1'b1) begin
            int got;
            int exp;
            got = int'(o_prgmem_addr) * 8 + int'(o_prgmem_data);
            nvec++;
            if (expq.size() == 0) begin
                nfail++;
                $display("FAIL write_unexpected: got addr=%0d data=%0d, required no write",
                         o_prgmem_addr, o_prgmem_data);
            end else begin
                exp = expq.pop_front();
                if (got != exp) begin
                    nfail++;
                    $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             got / 8, got % 8, exp / 8, exp % 8);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_byte_valid = 1'b0;
        i_byte_data  = 8'h00;
        i_byte_last  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        i_byte_last  = last;
        while (!o_byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_byte_ready) check("ready_timeout", 0, 1);
        tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], (i == s.len() - 1));
        end
        idle();
    endtask

    task automatic push_w(input int a, input int d);
        expq.push_back(a * 8 + d);
    endtask

    task automatic push_fill(input int from);
        for (int a = from; a < DEPTH; a++) push_w(a, 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(o_core_reset_n || o_error) && n < 1000) begin
            tick();
            n++;
        end
        check("done_within_budget", int'(n < 1000), 1);
        repeat (2) tick();
        check("writes_drained", expq.size(), 0);
    endtask

    task automatic check_run(input int len);
        check("run_core_reset_n", int'(o_core_reset_n), 1);
        check("run_busy", int'(o_busy), 0);
        check("run_error", int'(o_error), 0);
        check("run_ready", int'(o_byte_ready), 0);
        check("run_length", int'(o_length), len);
    endtask

    task automatic check_err(input int code, input int len);
        check("err_error", int'(o_error), 1);
        check("err_code", int'(o_error_code), code);
        check("err_core_reset_n", int'(o_core_reset_n), 0);
        check("err_busy", int'(o_busy), 0);
        check("err_ready", int'(o_byte_ready), 0);
        check("err_length", int'(o_length), len);
    endtask

    task automatic do_load(input logic with_byte);
        i_load = 1'b1;
        if (with_byte) begin
            i_byte_valid = 1'b1;
            i_byte_data  = "+";
            i_byte_last  = 1'b1;
        end
        tick();
        i_load = 1'b0;
        idle();
        check("load_core_reset_n", int'(o_core_reset_n), 0);
        check("load_busy", int'(o_busy), 1);
        check("load_ready", int'(o_byte_ready), 1);
        check("load_error", int'(o_error), 0);
        check("load_length", int'(o_length), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        i_load = 1'b0;
        idle();
        #12;
        check("rst_prgmem_in", int'(o_prgmem_in), 0);
        check("rst_addr", int'(o_prgmem_addr), 0);
        check("rst_data", int'(o_prgmem_data), 0);
        check("rst_core_reset_n", int'(o_core_reset_n), 0);
        check("rst_busy", int'(o_busy), 1);
        check("rst_error", int'(o_error), 0);
        check("rst_code", int'(o_error_code), 0);
        check("rst_length", int'(o_length), 0);
        check("rst_ready", int'(o_byte_ready), 1);
        rst_n = 1'b1;
        tick();

        // Balanced loop program
        push_w(0, 2); push_w(1, 6); push_w(2, 3); push_w(3, 7); push_w(4, 4);
        push_fill(5);
        send_str("+[-]>");
        wait_done();
        check_run(5);

        // Reload from RUN; a byte offered with i_load must be dropped
        do_load(1'b1);

        // Comment bytes are consumed but not written
        push_w(0, 2); push_w(1, 3);
        push_fill(2);
        send_str("a+ b\n-");
        wait_done();
        check_run(2);
        do_load(1'b0);

        // Unmatched close
        send_str("]");
        wait_done();
        check_err(1, 0);
        do_load(1'b0);

        // Open loops left at end of program
        push_w(0, 6); push_w(1, 6);
        send_str("[[");
        wait_done();
        check_err(1, 2);
        do_load(1'b0);

        // Nesting one deeper than the stack allows
        for (int i = 0; i < 16; i++) push_w(i, 6);
        for (int i = 0; i < 17; i++) send("[", (i == 16));
        idle();
        wait_done();
        check_err(2, 16);
        do_load(1'b0);

        // Program one instruction too long
        for (int i = 0; i < DEPTH - 1; i++) push_w(i, 2);
        for (int i = 0; i < DEPTH; i++) send("+", (i == DEPTH - 1));
        idle();
        wait_done();
        check_err(3, DEPTH - 1);
        do_load(1'b0);

        // Asynchronous reset in the middle of FILL
        push_w(0, 2);
        push_fill(1);
        send_str("+");
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("midfill_prgmem_in", int'(o_prgmem_in), 0);
        check("midfill_addr", int'(o_prgmem_addr), 0);
        check("midfill_data", int'(o_prgmem_data), 0);
        check("midfill_core_reset_n", int'(o_core_reset_n), 0);
        check("midfill_busy", int'(o_busy), 1);
        check("midfill_error", int'(o_error), 0);
        check("midfill_length", int'(o_length), 0);
        check("midfill_ready", int'(o_byte_ready), 1);
        expq.delete();
        #1;
        rst_n = 1'b1;
        tick();

        // Empty program: only a comment byte, flagged last
        push_fill(0);
        send_str("x");
        wait_done();
        check_run(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
